toggle_cover_scheduler: RTL and testbench
=========================================

// Module: toggle_cover_scheduler
// PURPOSE
//  Collects raw toggle-hit vectors from NUM_GRP toggle cover groups and serialises first-time hits
//  into one cover-index stream (valid/ready) for a single DPI/trace sink.
//  Sits between the per-signal toggle cover groups and the coverage reporter.
//  Reports each bit at most once until cleared; no hit is ever dropped.
// PARAMETERS
//  NUM_GRP     4     number of toggle cover groups
//  GRP_W       7     hit bits per group
//  COVER_BASE  0     cover index of group0 bit0; index = COVER_BASE + g*GRP_W + b
//  IDX_W       32    width of out_index
//  CNT_W       16    width of covered_count (must hold NUM_GRP*GRP_W)
// PORTS
//  clock          in   1               sole clock, posedge
//  reset          in   1               synchronous, active-low (0 = in reset)
//  hit            in   NUM_GRP*GRP_W   raw toggle hits; group g = hit[g*GRP_W +: GRP_W]
//  enable         in   1               0: hit ignored; queued work still drains
//  clear_req      in   1               pulse: drain, then forget the seen history
//  out_valid      out  1               out_index is valid
//  out_index      out  IDX_W           cover index being reported
//  out_ready      in   1               sink accepts; fire = out_valid & out_ready
//  covered_count  out  CNT_W           number of indices reported since the last clear
//  clear_done     out  1               1-cycle pulse when a clear completes
//  busy           out  1               pending != 0 | out_valid | state == DRAIN
// BEHAVIOUR
//  State
//   - pending and seen bitmaps, each NUM_GRP*GRP_W bits.
//   - RR pointer rr_ptr, 0..NUM_GRP-1.
//   - Single output register: out_valid, out_index.
//   - FSM {ACTIVE, DRAIN}.
//  Reset (reset==0 at posedge)
//   - pending = 0, seen = 0, rr_ptr = 0.
//   - out_valid = 0, out_index = 0, covered_count = 0, clear_done = 0.
//   - state = ACTIVE. Reset mid-operation discards all queued hits.
//  Capture (ACTIVE && enable)
//   - new = hit & ~seen & ~pending; pending |= new at the next edge.
//   - Hits on a bit that is already pending, or being loaded this cycle, are absorbed (no duplicate).
//  Select
//   - A group is eligible if any of its pending bits is set.
//   - RR over eligible groups, starting at rr_ptr; lowest set bit within the winning group.
//  Load
//   - Condition: out register empty or fire this cycle, and a winner exists.
//   - Effects: out_index = COVER_BASE + g*GRP_W + b; out_valid = 1.
//   - Clear that pending bit and set its seen bit. rr_ptr = (g+1) mod NUM_GRP.
//   - With no winner, fire clears out_valid.
//  Output handshake
//   - out_valid/out_index hold stable while !out_ready.
//   - Sustained throughput is one index per cycle.
//  Count
//   - covered_count += 1 on each fire; saturates at its all-ones value.
//  Latency
//   - Hit sampled at edge t sets pending at t.
//   - Uncontended, it is loaded at edge t+1, so out_valid is visible the cycle after capture.
//  FSM
//   - ACTIVE -> DRAIN on clear_req. In DRAIN, capture is disabled.
//   - DRAIN -> ACTIVE when pending==0 && (!out_valid || fire).
//     - At that edge: seen = 0, covered_count = 0, clear_done = 1 for one cycle.
//   - clear_req while in DRAIN is ignored.
//  Boundaries
//   - All bits hit in one cycle: all reported over NUM_GRP*GRP_W consecutive fires.
//   - Fairness: with all groups pending, consecutive reports rotate g0, g1, g2, g3, g0...
//   - RR wrap: after the last group, rr_ptr returns to 0.
//   - out_ready stuck at 0: pending accumulates; nothing is lost; there is no overflow path.
//   - enable==0 does not block draining or clear.
// STRUCTURE
//  Package toggle_cover_pkg:
//   - sched_state_e {ACTIVE, DRAIN}
//   - localparam TOTAL = NUM_GRP*GRP_W
//   - function grp_any(), the per-group OR reduce
//  Sub-module cover_rr_arb:
//   - Parameterised NUM_GRP round-robin arbiter.
//   - In: req vector, rr_ptr. Out: one-hot grant and encoded index.
//  Top: bitmaps, priority encoder within the granted group, output register, FSM, counter.
//  Simulation-only code sits behind `ifndef SYNTHESIS.
// TESTING
//  1. Reset: hold reset=0 for 3 cycles with hit all-ones.
//     -> out_valid=0, covered_count=0, busy=0 after release.
//  2. Single hit: hit bit (g1,b2) for 1 cycle with COVER_BASE=100, out_ready=1.
//     -> out_index=109 one cycle after capture, count=1.
//     Re-hitting the same bit gives no new report.
//  3. Burst and fairness: all 28 bits hit in one cycle, out_ready=1.
//     -> 28 consecutive fires, unique indices 100..127.
//     Group order g0,g1,g2,g3 repeating; count=28.
//  4. Backpressure: out_ready=0 for 10 cycles while hitting 5 bits.
//     -> out_index stable, busy=1; after release, exactly 5 distinct fires.
//  5. Clear: clear_req while 3 bits are pending.
//     -> the 3 bits drain; clear_done pulses; count=0.
//     Re-hitting the same bits reports them again.
//  6. Reset mid-drain: assert reset during DRAIN.
//     -> clear_done is never pulsed; all state returns to reset values.

Source files
------------

// File: rtl/toggle_cover_pkg.sv
// Shared types and sizing for the toggle-cover scheduler.
// Group geometry lives here so the arbiter, top and bench agree on it.
package toggle_cover_pkg;

    localparam int NUM_GRP = 4;
    localparam int GRP_W   = 7;
    localparam int TOTAL   = NUM_GRP * GRP_W;

    typedef enum logic {
        ACTIVE = 1'b0,
        DRAIN  = 1'b1
    } sched_state_e;

    // OR-reduce of one group's slice of a full-width bitmap.
    function automatic logic grp_any(input logic [TOTAL-1:0] bits, input int g);
        return |bits[g*GRP_W +: GRP_W];
    endfunction

endpackage

// File: rtl/cover_rr_arb.sv
// Round-robin arbiter.
// The search starts at rr_ptr_i and grants the first requesting group at or after it.
module cover_rr_arb #(
    parameter int NUM_GRP = 4,
    parameter int PTR_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1
) (
    input  logic [NUM_GRP-1:0] req_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [NUM_GRP-1:0] grant_o,
    output logic [PTR_W-1:0]   grant_idx_o,
    output logic               grant_valid_o
);

    int g;

    // The scan runs from the farthest offset down to the nearest one.
    // This leaves the group closest to rr_ptr_i as the final winner.
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        g             = 0;
        for (int k = NUM_GRP - 1; k >= 0; k--) begin
            g = (int'(rr_ptr_i) + k) % NUM_GRP;
            if (req_i[g]) begin
                grant_o       = '0;
                grant_o[g]    = 1'b1;
                grant_idx_o   = PTR_W'(g);
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/toggle_cover_scheduler.sv
// Serialises first-time toggle hits from NUM_GRP cover groups into one valid/ready index stream.
// Each bit is reported at most once until a clear, and no captured hit is ever dropped.
module toggle_cover_scheduler
    import toggle_cover_pkg::*;
#(
    parameter int unsigned COVER_BASE = 0,
    parameter int          IDX_W      = 32,
    parameter int          CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [TOTAL-1:0] hit,
    input  logic             enable,
    input  logic             clear_req,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    input  logic             out_ready,
    output logic [CNT_W-1:0] covered_count,
    output logic             clear_done,
    output logic             busy
);

    localparam int PTR_W = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam int BIT_W = (GRP_W > 1) ? $clog2(GRP_W) : 1;

    logic [TOTAL-1:0] pending_q, pending_d;
    logic [TOTAL-1:0] seen_q, seen_d;
    logic [TOTAL-1:0] new_hits, load_mask;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    sched_state_e     state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             clear_done_q, clear_done_d;

    logic [NUM_GRP-1:0] grp_req, grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_valid;
    logic [GRP_W-1:0]   win_slice;
    logic [BIT_W-1:0]   win_bit;
    logic               fire, load, drain_done;

    always_comb begin
        grp_req = '0;
        for (int g = 0; g < NUM_GRP; g++) grp_req[g] = grp_any(pending_q, g);
    end

    cover_rr_arb #(
        .NUM_GRP (NUM_GRP),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_i         (grp_req),
        .rr_ptr_i      (rr_ptr_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    // Lowest pending bit inside the granted group.
    always_comb begin
        win_slice = '0;
        for (int g = 0; g < NUM_GRP; g++) begin
            if (grant[g]) win_slice = win_slice | pending_q[g*GRP_W +: GRP_W];
        end
        win_bit = '0;
        for (int b = GRP_W - 1; b >= 0; b--) begin
            if (win_slice[b]) win_bit = BIT_W'(b);
        end
    end

    always_comb begin
        fire       = out_valid_q & out_ready;
        load       = (!out_valid_q || fire) && grant_valid;
        drain_done = (state_q == DRAIN) && (pending_q == '0) && (!out_valid_q || fire);

        load_mask = '0;
        if (load) load_mask[int'(grant_idx)*GRP_W + int'(win_bit)] = 1'b1;

        // Pending bits are excluded here, so a bit being loaded this cycle is absorbed.
        new_hits  = (state_q == ACTIVE && enable) ? (hit & ~seen_q & ~pending_q) : '0;
        pending_d = (pending_q & ~load_mask) | new_hits;
        seen_d    = seen_q | load_mask;

        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_index_d = IDX_W'(COVER_BASE) + IDX_W'(int'(grant_idx) * GRP_W + int'(win_bit));
            rr_ptr_d    = (grant_idx == PTR_W'(NUM_GRP - 1)) ? '0 : grant_idx + 1'b1;
        end else if (fire) begin
            out_valid_d = 1'b0;
        end

        count_d = count_q;
        if (fire && count_q != '1) count_d = count_q + 1'b1;

        state_d      = state_q;
        clear_done_d = 1'b0;
        case (state_q)
            ACTIVE: if (clear_req) state_d = DRAIN;
            DRAIN: begin
                if (drain_done) begin
                    state_d      = ACTIVE;
                    seen_d       = '0;
                    count_d      = '0;
                    clear_done_d = 1'b1;
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

    // NOTE: the bitmaps are plain flops rather than a RAM, so reset clears them.
    // This is what makes reset mid-operation discard all queued hits.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pending_q    <= '0;
            seen_q       <= '0;
            rr_ptr_q     <= '0;
            state_q      <= ACTIVE;
            out_valid_q  <= 1'b0;
            out_index_q  <= '0;
            count_q      <= '0;
            clear_done_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            seen_q       <= seen_d;
            rr_ptr_q     <= rr_ptr_d;
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_index_q  <= out_index_d;
            count_q      <= count_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_index     = out_index_q;
    assign covered_count = count_q;
    assign clear_done    = clear_done_q;
    assign busy          = (pending_q != '0) | out_valid_q | (state_q == DRAIN);

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset && load) begin
            assert ((load_mask & seen_q) == '0)
                else $error("cover scheduler re-reported an already seen bit");
        end
    end
`endif

endmodule

// File: tb/tb_toggle_cover_scheduler.sv
// Directed bench for toggle_cover_scheduler with COVER_BASE=100.
// Expected indices follow the formula 100 + g*7 + b.
module tb_toggle_cover_scheduler;
    import toggle_cover_pkg::*;

    localparam int BASE = 100;

    logic             clock = 1'b0;
    logic             reset;
    logic [TOTAL-1:0] hit;
    logic             enable;
    logic             clear_req;
    logic             out_valid;
    logic [31:0]      out_index;
    logic             out_ready;
    logic [15:0]      covered_count;
    logic             clear_done;
    logic             busy;

    int checks = 0;
    int errors = 0;

    toggle_cover_scheduler #(
        .COVER_BASE (BASE),
        .IDX_W      (32),
        .CNT_W      (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .hit           (hit),
        .enable        (enable),
        .clear_req     (clear_req),
        .out_valid     (out_valid),
        .out_index     (out_index),
        .out_ready     (out_ready),
        .covered_count (covered_count),
        .clear_done    (clear_done),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            end
    endtask

    function automatic logic [TOTAL-1:0] bits(input int a, input int b = -1, input int c = -1,
                                              input int d = -1, input int e = -1);
        logic [TOTAL-1:0] m;
        m = '0;
        m[a] = 1'b1;
        if (b >= 0) m[b] = 1'b1;
        if (c >= 0) m[c] = 1'b1;
        if (d >= 0) m[d] = 1'b1;
        if (e >= 0) m[e] = 1'b1;
        return m;
    endfunction

    initial begin
        int exp_list[4];

        // 1. Reset held with all hits asserted.
        reset = 1'b0; hit = '1; enable = 1'b1; clear_req = 1'b0; out_ready = 1'b1;
        step(3);
        check("rst_hold_valid", 32'(out_valid), 0);
        check("rst_hold_busy", 32'(busy), 0);
        reset = 1'b1; hit = '0;
        step();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_count", 32'(covered_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_clear_done", 32'(clear_done), 0);

        // 2. A single hit on (g1,b2) is reported as 109 and is never repeated.
        hit = bits(9);
        step();
        check("single_lat_valid", 32'(out_valid), 0);
        check("single_lat_busy", 32'(busy), 1);
        hit = '0;
        step();
        check("single_valid", 32'(out_valid), 1);
        check("single_index", out_index, 109);
        step();
        check("single_count", 32'(covered_count), 1);
        check("single_drained", 32'(out_valid), 0);
        hit = bits(9);
        step();
        hit = '0;
        step(2);
        check("rehit_valid", 32'(out_valid), 0);
        check("rehit_count", 32'(covered_count), 1);
        check("rehit_busy", 32'(busy), 0);

        // 3. All bits in one cycle yield 28 back-to-back reports rotating g0..g3.
        reset = 1'b0;
        step();
        reset = 1'b1;
        hit = '1;
        step();
        hit = '0;
        for (int k = 0; k < TOTAL; k++) begin
            step();
            check($sformatf("burst_valid_%0d", k), 32'(out_valid), 1);
            check($sformatf("burst_index_%0d", k), out_index, 32'(BASE + (k % 4) * 7 + k / 4));
        end
        step();
        check("burst_done_valid", 32'(out_valid), 0);
        check("burst_count", 32'(covered_count), 28);
        check("burst_busy", 32'(busy), 0);

        // 4. Backpressure: five bits are hit while out_ready is held low for 10 cycles.
        reset = 1'b0;
        step();
        reset = 1'b1;
        out_ready = 1'b0;
        hit = bits(0, 3, 8, 15, 22);
        step();
        check("bp_capture_valid", 32'(out_valid), 0);
        check("bp_capture_busy", 32'(busy), 1);
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("bp_hold_valid_%0d", k), 32'(out_valid), 1);
            check($sformatf("bp_hold_index_%0d", k), out_index, 100);
            check($sformatf("bp_hold_busy_%0d", k), 32'(busy), 1);
        end
        hit = '0;
        out_ready = 1'b1;
        exp_list = '{108, 115, 122, 103};
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("bp_drain_valid_%0d", k), 32'(out_valid), 1);
            check($sformatf("bp_drain_index_%0d", k), out_index, 32'(exp_list[k]));
        end
        step();
        check("bp_done_valid", 32'(out_valid), 0);
        check("bp_count", 32'(covered_count), 5);

        // 5. A clear issued with three bits pending drains them, then forgets the history.
        out_ready = 1'b0;
        hit = bits(1, 2, 9);
        step();
        check("clr_pending_busy", 32'(busy), 1);
        hit = '0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check("clr_first_index", out_index, 109);
        check("clr_first_done", 32'(clear_done), 0);
        hit = bits(27);
        out_ready = 1'b1;
        step();
        check("clr_second_index", out_index, 101);
        check("clr_count_6", 32'(covered_count), 6);
        check("clr_mid_done", 32'(clear_done), 0);
        step();
        check("clr_third_index", out_index, 102);
        check("clr_count_7", 32'(covered_count), 7);
        hit = '0;
        step();
        check("clr_done_pulse", 32'(clear_done), 1);
        check("clr_count_zero", 32'(covered_count), 0);
        check("clr_valid_zero", 32'(out_valid), 0);
        check("clr_busy_zero", 32'(busy), 0);
        step();
        check("clr_done_low", 32'(clear_done), 0);
        check("clr_drain_hit_ignored", 32'(out_valid), 0);
        hit = bits(1, 2, 9);
        step();
        hit = '0;
        exp_list = '{109, 101, 102, 0};
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("clr_rehit_valid_%0d", k), 32'(out_valid), 1);
            check($sformatf("clr_rehit_index_%0d", k), out_index, 32'(exp_list[k]));
        end
        step();
        check("clr_rehit_count", 32'(covered_count), 3);

        // 6. A reset during DRAIN abandons the clear without a clear_done pulse.
        out_ready = 1'b0;
        hit = bits(5);
        step();
        hit = '0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check("rstdrain_index", out_index, 105);
        check("rstdrain_busy", 32'(busy), 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("rstdrain_valid", 32'(out_valid), 0);
        check("rstdrain_out_index", out_index, 0);
        check("rstdrain_count", 32'(covered_count), 0);
        check("rstdrain_busy_zero", 32'(busy), 0);
        check("rstdrain_done", 32'(clear_done), 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rstdrain_no_pulse_%0d", k), 32'(clear_done), 0);
        end
        hit = bits(1);
        step();
        hit = '0;
        step();
        check("rstdrain_seen_cleared_valid", 32'(out_valid), 1);
        check("rstdrain_seen_cleared_index", out_index, 101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
